async_receiver: RTL

UART receiver, 8N1, LSB first. It is the receive-side counterpart of async_transmitter and runs on the 10 MHz board clock. It oversamples the serial line, presents each received byte through a valid/ack holding register, and flags framing errors, overruns and inter-packet idle gaps. It feeds host-command parsing from connector B and the bill-validator link.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 27 ++
 rtl/async_receiver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-rate helpers.
// Also used by the transmit side, which shares the tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam int DEF_OVERSAMPLING = 16;
    localparam int MAJ_MID          = DEF_OVERSAMPLING / 2;

    // Rounded phase increment so that the accumulator carry fires Baud*Oversampling times per second
    function automatic int calc_inc(input int clk_hz, input int baud, input int os, input int acc_w);
        longint num;
        num = (longint'(baud) * longint'(os)) <<< acc_w;
        return int'((num + longint'(clk_hz / 2)) / longint'(clk_hz));
    endfunction

    function automatic int maj_mid(input int os);
        return os / 2;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: the accumulator carry is a one-cycle tick
// at Baud*Oversampling on average.
module baud_tick_gen #(
    parameter int AccWidth = 16,
    parameter int Inc      = 12080
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam logic [AccWidth:0] INC_V = Inc[AccWidth:0];

    logic [AccWidth:0] r_acc;

    // Phase accumulator; the previous carry is dropped before each add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {(AccWidth + 1){1'b0}};
        end else begin
            r_acc <= {1'b0, r_acc[AccWidth-1:0]} + INC_V;
        end
    end

    assign o_tick = r_acc[AccWidth];

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver with 3-sample majority voting, valid/ack holding register,
// framing/overrun pulses and idle-gap / end-of-packet detection.
module async_receiver #(
    parameter int ClkFrequency = 10000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16,
    parameter int AccWidth     = 16,
    parameter int IdleBits     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);
    import uart_pkg::*;

    localparam int OSW     = $clog2(Oversampling);
    localparam int INC     = calc_inc(ClkFrequency, Baud, Oversampling, AccWidth);
    localparam int MID     = maj_mid(Oversampling);
    localparam int GAP_MAX = IdleBits * Oversampling;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam logic [OSW-1:0] CNT_S0  = OSW'(MID - 1);
    localparam logic [OSW-1:0] CNT_S1  = OSW'(MID);
    localparam logic [OSW-1:0] CNT_S2  = OSW'(MID + 1);
    localparam logic [GW-1:0]  GAP_SAT = GW'(GAP_MAX);

    logic            w_tick;
    logic            w_maj;
    logic            w_at_maj;
    logic            r_rx_meta;
    logic            r_rxs;
    rx_state_t       r_state;
    logic [OSW-1:0]  r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [1:0]      r_samp;
    logic [7:0]      r_shift;
    logic            r_done;
    logic            r_frm;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ovr;
    logic [GW-1:0]   r_gap;
    logic            r_idle;
    logic            r_eop;
    logic            r_got_byte;

    baud_tick_gen #(
        .AccWidth (AccWidth),
        .Inc      (INC)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // The third vote is the live synced sample on the decision tick
    assign w_maj    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rxs) | (r_samp[1] & r_rxs);
    assign w_at_maj = w_tick && (r_tick_cnt == CNT_S2);

    // Two-flop synchronizer, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rxs     <= r_rx_meta;
        end
    end

    // Frame state machine; r_done / r_frm are single-cycle results of the stop-bit vote
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_tick_cnt <= {OSW{1'b0}};
            r_bit_cnt  <= 3'd0;
            r_samp     <= 2'b00;
            r_shift    <= 8'h00;
            r_done     <= 1'b0;
            r_frm      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_frm  <= 1'b0;
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + OSW'(1);
                if (r_tick_cnt == CNT_S0) r_samp[0] <= r_rxs;
                if (r_tick_cnt == CNT_S1) r_samp[1] <= r_rxs;
                case (r_state)
                    RX_IDLE: begin
                        if (!r_rxs) begin
                            r_state    <= RX_START;
                            r_tick_cnt <= {OSW{1'b0}};
                        end
                    end
                    RX_START: begin
                        if (w_at_maj) begin
                            r_state   <= w_maj ? RX_IDLE : RX_DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        if (w_at_maj) begin
                            r_shift   <= {w_maj, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (w_at_maj) begin
                            if (w_maj) begin
                                r_done  <= 1'b1;
                                r_state <= RX_IDLE;
                            end else begin
                                r_frm   <= 1'b1;
                                r_state <= RX_BREAK;
                            end
                        end
                    end
                    RX_BREAK: begin
                        if (r_rxs) r_state <= RX_IDLE;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    // Holding register: a completion with a simultaneous ack replaces the byte instead of overrunning
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_done) begin
                if (!r_ready || rd_ack) begin
                    r_data  <= r_shift;
                    r_ready <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rd_ack && r_ready) begin
                r_ready <= 1'b0;
            end
        end
    end

    // Idle-gap counter and end-of-packet; only good bytes arm the end-of-packet pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap      <= {GW{1'b0}};
            r_idle     <= 1'b0;
            r_eop      <= 1'b0;
            r_got_byte <= 1'b0;
        end else begin
            if (w_tick && (r_state == RX_IDLE)) begin
                if (!r_rxs) begin
                    r_gap <= {GW{1'b0}};
                end else if (r_gap != GAP_SAT) begin
                    r_gap <= r_gap + GW'(1);
                end
            end
            r_idle <= (r_gap == GAP_SAT);
            r_eop  <= 1'b0;
            if ((r_gap == GAP_SAT) && !r_idle && r_got_byte) begin
                r_eop      <= 1'b1;
                r_got_byte <= 1'b0;
            end else if (r_done) begin
                r_got_byte <= 1'b1;
            end
        end
    end

    assign RxD_data        = r_data;
    assign RxD_data_ready  = r_ready;
    assign framing_error   = r_frm;
    assign overrun         = r_ovr;
    assign RxD_idle        = r_idle;
    assign RxD_endofpacket = r_eop;

endmodule
